// File: rtl/uart_tx_fifo_if_if.sv
// Producer/uart_tx handshake bundle for the transmit FIFO.
// The master modport is the producer/uart_tx side; the slave modport is the FIFO.
interface uart_tx_fifo_if_if #(
    parameter int unsigned NBITS_DATA = 8,
    parameter int unsigned ADDR_BITS  = 4
);
    logic                  i_wr;
    logic [NBITS_DATA-1:0] i_wr_data;
    logic                  o_full;
    logic                  o_empty;
    logic [ADDR_BITS:0]    o_count;
    logic                  o_overflow;
    logic                  i_tx_done;
    logic                  o_tx_start;
    logic [NBITS_DATA-1:0] o_tx_data;

    modport master (
        output i_wr, i_wr_data, i_tx_done,
        input  o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );

    modport slave (
        input  i_wr, i_wr_data, i_tx_done,
        output o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/uart_tx_fifo_if.sv
// Transmit-side circular FIFO feeding uart_tx one byte at a time:
// single-cycle start strobe, data held until uart_tx reports done.
module uart_tx_fifo_if #(
    parameter int unsigned NBITS_DATA = 8,
    parameter int unsigned ADDR_BITS  = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    uart_tx_fifo_if_if.slave  fifo
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    logic [NBITS_DATA-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count;
    state_t                state;
    logic [NBITS_DATA-1:0] tx_data;
    logic                  overflow;

    logic pop;
    logic full;
    logic wr_accept;

    // A pop frees a slot on the same edge, so a write into a full FIFO is still taken
    assign full      = (count == DEPTH_CNT);
    assign pop       = (state == IDLE) && (count != '0);
    assign wr_accept = fifo.i_wr && (!full || pop);

    assign fifo.o_full     = full;
    assign fifo.o_empty    = (count == '0);
    assign fifo.o_count    = count;
    assign fifo.o_overflow = overflow;
    assign fifo.o_tx_start = (state == START);
    assign fifo.o_tx_data  = tx_data;

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= fifo.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= fifo.i_wr && full && !pop;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        state   <= START;
                    end
                end
                START: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (fifo.i_tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_if.sv
// Directed self-checking bench for uart_tx_fifo_if: reset, latency, ordering,
// overflow, simultaneous pop/write at full, and reset during a transfer.
module tb_uart_tx_fifo_if;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    uart_tx_fifo_if_if #(.NBITS_DATA(8), .ADDR_BITS(4)) bus ();

    uart_tx_fifo_if #(.NBITS_DATA(8), .ADDR_BITS(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .fifo    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.i_wr      = 1'b0;
        bus.i_wr_data = '0;
        bus.i_tx_done = 1'b0;

        // Reset held with write strobe toggling
        for (int i = 0; i < 4; i++) begin
            bus.i_wr      = i[0];
            bus.i_wr_data = 8'hC0 + 8'(i);
            tick();
            chk("rst_start", 32'(bus.o_tx_start), 32'd0);
            chk("rst_data",  32'(bus.o_tx_data),  32'h00);
            chk("rst_empty", 32'(bus.o_empty),    32'd1);
            chk("rst_count", 32'(bus.o_count),    32'd0);
        end
        chk("rst_full", 32'(bus.o_full),     32'd0);
        chk("rst_ovf",  32'(bus.o_overflow), 32'd0);
        bus.i_wr = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Single byte latency
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h33;
        tick();
        bus.i_wr = 1'b0;
        chk("s_count_n",  32'(bus.o_count),    32'd1);
        chk("s_start_n",  32'(bus.o_tx_start), 32'd0);
        tick();
        chk("s_start",    32'(bus.o_tx_start), 32'd1);
        chk("s_data",     32'(bus.o_tx_data),  32'h33);
        chk("s_empty",    32'(bus.o_empty),    32'd1);
        tick();
        chk("s_start_1c", 32'(bus.o_tx_start), 32'd0);
        tick(); tick();
        chk("s_hold",     32'(bus.o_tx_data),  32'h33);
        chk("s_nostart",  32'(bus.o_tx_start), 32'd0);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("s_idle",     32'(bus.o_tx_start), 32'd0);
        tick();
        chk("s_quiet",    32'(bus.o_tx_start), 32'd0);

        // Ordering and back-to-back spacing
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h33;
        tick();
        bus.i_wr_data = 8'hF2;
        tick();
        chk("b_start0", 32'(bus.o_tx_start), 32'd1);
        chk("b_data0",  32'(bus.o_tx_data),  32'h33);
        chk("b_cnt0",   32'(bus.o_count),    32'd1);
        bus.i_wr_data = 8'hA5;
        tick();
        bus.i_wr = 1'b0;
        chk("b_cnt1",   32'(bus.o_count),    32'd2);
        chk("b_off",    32'(bus.o_tx_start), 32'd0);
        tick(); tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("b_gap1",   32'(bus.o_tx_start), 32'd0);
        tick();
        chk("b_start1", 32'(bus.o_tx_start), 32'd1);
        chk("b_data1",  32'(bus.o_tx_data),  32'hF2);
        chk("b_cnt2",   32'(bus.o_count),    32'd1);
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("b_gap2",   32'(bus.o_tx_start), 32'd0);
        tick();
        chk("b_start2", 32'(bus.o_tx_start), 32'd1);
        chk("b_data2",  32'(bus.o_tx_data),  32'hA5);
        chk("b_cnt3",   32'(bus.o_count),    32'd0);
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        tick();

        // Fill while stalled in WAIT, then overflow
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h00;
        tick();
        bus.i_wr = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            bus.i_wr = 1'b1; bus.i_wr_data = 8'h80 + 8'(i);
            tick();
        end
        chk("f_count", 32'(bus.o_count), 32'd16);
        chk("f_full",  32'(bus.o_full),  32'd1);
        chk("f_ovf0",  32'(bus.o_overflow), 32'd0);
        bus.i_wr_data = 8'hEE;
        tick();
        bus.i_wr = 1'b0;
        chk("o_ovf",   32'(bus.o_overflow), 32'd1);
        chk("o_count", 32'(bus.o_count),    32'd16);
        tick();
        chk("o_ovf_1c", 32'(bus.o_overflow), 32'd0);
        chk("o_stall",  32'(bus.o_tx_start), 32'd0);

        // Write in the pop cycle while full
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h5A;
        tick();
        bus.i_wr = 1'b0;
        chk("w_ovf",   32'(bus.o_overflow), 32'd0);
        chk("w_count", 32'(bus.o_count),    32'd16);
        chk("w_start", 32'(bus.o_tx_start), 32'd1);
        chk("w_data",  32'(bus.o_tx_data),  32'h80);
        for (int k = 1; k <= 16; k++) begin
            tick();
            bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
            tick();
            chk("d_start", 32'(bus.o_tx_start), 32'd1);
            chk("d_data",  32'(bus.o_tx_data), (k < 16) ? 32'h80 + 32'(k) : 32'h5A);
        end
        chk("d_empty", 32'(bus.o_empty), 32'd1);
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        tick();

        // Reset during WAIT with 5 bytes queued
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h01;
        tick();
        bus.i_wr = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            bus.i_wr = 1'b1; bus.i_wr_data = 8'h02 + 8'(i);
            tick();
        end
        bus.i_wr = 1'b0;
        chk("r_count5", 32'(bus.o_count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("r_start", 32'(bus.o_tx_start), 32'd0);
        chk("r_data",  32'(bus.o_tx_data),  32'h00);
        chk("r_count", 32'(bus.o_count),    32'd0);
        chk("r_empty", 32'(bus.o_empty),    32'd1);
        tick();
        rst_n = 1'b1;
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        tick();
        chk("r_ignore", 32'(bus.o_tx_start), 32'd0);
        chk("r_cnt0",   32'(bus.o_count),    32'd0);
        bus.i_wr = 1'b1; bus.i_wr_data = 8'h77;
        tick();
        bus.i_wr = 1'b0;
        tick();
        chk("r_start2", 32'(bus.o_tx_start), 32'd1);
        chk("r_data2",  32'(bus.o_tx_data),  32'h77);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
